// File: rtl/nco_pkg.sv
// Shared definitions for the NCO phase generator: FSM states, mode encodings, default widths.
package nco_pkg;

    localparam int unsigned ACC_W_DEF     = 16;
    localparam int unsigned PH_W_DEF      = 10;
    localparam int unsigned SWEEP_DIV_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWEEP = 2'd2
    } nco_state_e;

    // Mode 3 is reserved and behaves like continuous.
    typedef enum logic [1:0] {
        MODE_CONT   = 2'd0,
        MODE_SWEEP  = 2'd1,
        MODE_SINGLE = 2'd2,
        MODE_RSVD   = 2'd3
    } nco_mode_e;

endpackage

// File: rtl/nco_phase_acc.sv
// Phase accumulator with registered phase-offset adder and carry-out (wrap) detection.
module nco_phase_acc
    import nco_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned PH_W  = PH_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             adv,
    input  logic             upd_x,
    input  logic [ACC_W-1:0] fcw,
    input  logic [PH_W-1:0]  phase_off,
    output logic [PH_W-1:0]  x,
    output logic             wrap,
    output logic             carry_c
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic [PH_W-1:0]  x_nxt;

    // Next accumulator value; the extra MSB is the carry out.
    assign sum     = {1'b0, acc} + {1'b0, fcw};
    assign carry_c = sum[ACC_W];
    assign x_nxt   = sum[ACC_W-1 -: PH_W] + phase_off;

    // Clear restarts at phase 0 (x = offset); x is only refreshed while the run continues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            x    <= '0;
            wrap <= 1'b0;
        end else if (clear) begin
            acc  <= '0;
            x    <= phase_off;
            wrap <= 1'b0;
        end else if (adv) begin
            acc  <= sum[ACC_W-1:0];
            wrap <= carry_c;
            if (upd_x) begin
                x <= x_nxt;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/nco_phase_gen.sv
// NCO phase generator: config capture, run/sweep FSM, sweep step counter around nco_phase_acc.
module nco_phase_gen
    import nco_pkg::*;
#(
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned PH_W      = PH_W_DEF,
    parameter int unsigned SWEEP_DIV = SWEEP_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [ACC_W-1:0] cfg_fcw,
    input  logic [ACC_W-1:0] cfg_fcw_end,
    input  logic [ACC_W-1:0] cfg_step,
    input  logic [PH_W-1:0]  cfg_phase_off,
    input  logic             start,
    input  logic             stop,
    output logic [PH_W-1:0]  x,
    output logic             x_valid,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      CNT_W    = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWEEP_DIV - 1);

    nco_state_e state, state_nxt;

    logic [1:0]       mode_q;
    logic [ACC_W-1:0] fcw_q, fcw_end_q, step_q;
    logic [PH_W-1:0]  off_q;

    logic             cfg_take;
    logic [1:0]       mode_e;
    logic [ACC_W-1:0] fcw_e;
    logic [PH_W-1:0]  off_e;

    logic [ACC_W-1:0] fcw_cur;
    logic [ACC_W:0]   fcw_sum;
    logic [ACC_W-1:0] fcw_sat;
    logic [CNT_W-1:0] cnt;
    logic             boundary;
    logic             sweep_end;
    logic             single_end;
    logic             acc_carry_c;

    logic clear, adv, upd_x, fcw_step, cnt_adv;
    logic valid_d, busy_d, done_d;

    // A config offered alongside start is used by that start.
    assign cfg_take = cfg_valid && cfg_ready;
    assign mode_e   = cfg_take ? cfg_mode      : mode_q;
    assign fcw_e    = cfg_take ? cfg_fcw       : fcw_q;
    assign off_e    = cfg_take ? cfg_phase_off : off_q;

    // Sweep bookkeeping: saturating step, block boundary, end-of-sweep (step 0 never ends).
    assign fcw_sum    = {1'b0, fcw_cur} + {1'b0, step_q};
    assign fcw_sat    = (fcw_sum >= {1'b0, fcw_end_q}) ? fcw_end_q : fcw_sum[ACC_W-1:0];
    assign boundary   = (cnt == CNT_LAST);
    assign sweep_end  = (step_q != '0) && (fcw_cur >= fcw_end_q);
    assign single_end = (mode_q == 2'(MODE_SINGLE)) && acc_carry_c;

    // Configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= '0;
            fcw_q     <= '0;
            fcw_end_q <= '0;
            step_q    <= '0;
            off_q     <= '0;
        end else if (cfg_take) begin
            mode_q    <= cfg_mode;
            fcw_q     <= cfg_fcw;
            fcw_end_q <= cfg_fcw_end;
            step_q    <= cfg_step;
            off_q     <= cfg_phase_off;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; stop wins over completion and start.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (mode_e == 2'(MODE_SWEEP)) ? ST_SWEEP : ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop || single_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (stop || (boundary && sweep_end)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath controls and next values of the registered status outputs.
    always_comb begin
        clear    = 1'b0;
        adv      = 1'b0;
        upd_x    = 1'b0;
        fcw_step = 1'b0;
        cnt_adv  = 1'b0;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!stop) begin
                    adv = 1'b1;
                    if (single_end) begin
                        done_d = 1'b1;
                    end else begin
                        upd_x   = 1'b1;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_SWEEP: begin
                if (!stop) begin
                    adv     = 1'b1;
                    cnt_adv = 1'b1;
                    if (boundary && sweep_end) begin
                        done_d = 1'b1;
                    end else begin
                        upd_x    = 1'b1;
                        valid_d  = 1'b1;
                        busy_d   = 1'b1;
                        fcw_step = boundary;
                    end
                end
            end
            default: ;
        endcase
    end

    // Current frequency word and sweep sample counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcw_cur <= '0;
            cnt     <= '0;
        end else begin
            if (clear) begin
                fcw_cur <= fcw_e;
            end else if (fcw_step) begin
                fcw_cur <= fcw_sat;
            end
            if (clear) begin
                cnt <= '0;
            end else if (cnt_adv) begin
                cnt <= boundary ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            x_valid   <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
            cfg_ready <= (state_nxt == ST_IDLE);
        end
    end

    nco_phase_acc #(
        .ACC_W (ACC_W),
        .PH_W  (PH_W)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .adv       (adv),
        .upd_x     (upd_x),
        .fcw       (fcw_cur),
        .phase_off (off_e),
        .x         (x),
        .wrap      (wrap),
        .carry_c   (acc_carry_c)
    );

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed bench for nco_phase_gen with default parameters (ACC_W=16, PH_W=10, SWEEP_DIV=8).
module tb_nco_phase_gen;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_fcw;
    logic [15:0] cfg_fcw_end;
    logic [15:0] cfg_step;
    logic [9:0]  cfg_phase_off;
    logic        start;
    logic        stop;
    logic [9:0]  x;
    logic        x_valid;
    logic        wrap;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] fcw;
        logic [15:0] fend;
        logic [15:0] step;
        logic [9:0]  off;
        int          ncyc;
        logic [9:0]  x;
        logic        valid;
        logic        wrap;
        logic        done;
        logic        busy;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    nco_phase_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_mode      (cfg_mode),
        .cfg_fcw       (cfg_fcw),
        .cfg_fcw_end   (cfg_fcw_end),
        .cfg_step      (cfg_step),
        .cfg_phase_off (cfg_phase_off),
        .start         (start),
        .stop          (stop),
        .x             (x),
        .x_valid       (x_valid),
        .wrap          (wrap),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Offer config and start in the same cycle; afterwards scramble the cfg inputs.
    task automatic launch(input logic [1:0] m, input logic [15:0] f, input logic [15:0] fe,
                          input logic [15:0] st, input logic [9:0] off);
        cfg_mode      = m;
        cfg_fcw       = f;
        cfg_fcw_end   = fe;
        cfg_step      = st;
        cfg_phase_off = off;
        cfg_valid     = 1'b1;
        start         = 1'b1;
        tick();
        cfg_valid     = 1'b0;
        start         = 1'b0;
        cfg_mode      = 2'd2;
        cfg_fcw       = 16'hA5A5;
        cfg_fcw_end   = 16'h0001;
        cfg_step      = 16'h1234;
        cfg_phase_off = 10'h155;
    endtask

    task automatic abort_run();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        launch(v.mode, v.fcw, v.fend, v.step, v.off);
        repeat (v.ncyc - 1) tick();
        check($sformatf("v%0d_x", idx),     32'(v.x),     32'(x));
        check($sformatf("v%0d_valid", idx), 32'(v.valid), 32'(x_valid));
        check($sformatf("v%0d_wrap", idx),  32'(v.wrap),  32'(wrap));
        check($sformatf("v%0d_done", idx),  32'(v.done),  32'(done));
        check($sformatf("v%0d_busy", idx),  32'(v.busy),  32'(busy));
        abort_run();
    endtask

    initial begin
        int exp_x;
        int wraps;
        int nvalid;
        int seen;
        int wrap_at_done;

        rst_n         = 1'b0;
        cfg_valid     = 1'b0;
        cfg_mode      = '0;
        cfg_fcw       = '0;
        cfg_fcw_end   = '0;
        cfg_step      = '0;
        cfg_phase_off = '0;
        start         = 1'b0;
        stop          = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_x",     32'(x),         32'd0);
        check("rst_valid", 32'(x_valid),   32'd0);
        check("rst_wrap",  32'(wrap),      32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // mode, fcw, fend, step, off, ncyc (sample k shows after k+1 cycles), x, valid, wrap, done, busy
        vecs[0]  = '{2'd0, 16'd64,    16'd0,   16'd0,   10'd0,   1,    10'd0,    1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{2'd0, 16'd64,    16'd0,   16'd0,   10'd256, 1,    10'd256,  1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{2'd0, 16'd64,    16'd0,   16'd0,   10'd256, 769,  10'd0,    1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{2'd0, 16'd64,    16'd0,   16'd0,   10'd0,   1025, 10'd0,    1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{2'd0, 16'd64,    16'd0,   16'd0,   10'd0,   1026, 10'd1,    1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{2'd3, 16'd64,    16'd0,   16'd0,   10'd0,   6,    10'd5,    1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{2'd0, 16'd1,     16'd0,   16'd0,   10'd3,   101,  10'd4,    1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{2'd0, 16'hFFFF,  16'd0,   16'd0,   10'd0,   3,    10'd1023, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{2'd2, 16'd1024,  16'd0,   16'd0,   10'd0,   64,   10'd1008, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{2'd2, 16'd1024,  16'd0,   16'd0,   10'd0,   65,   10'd1008, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{2'd2, 16'd1024,  16'd0,   16'd0,   10'd0,   66,   10'd1008, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{2'd1, 16'd64,    16'd256, 16'd64,  10'd0,   32,   10'd76,   1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{2'd1, 16'd64,    16'd256, 16'd64,  10'd0,   33,   10'd76,   1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{2'd1, 16'd300,   16'd256, 16'd64,  10'd0,   9,    10'd32,   1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{2'd1, 16'd64,    16'd256, 16'd0,   10'd0,   40,   10'd39,   1'b1, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{2'd1, 16'd64,    16'd256, 16'd128, 10'd0,   25,   10'd60,   1'b0, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Continuous ramp: x = k mod 1024, exactly one wrap within samples 1..1024
        launch(2'd0, 16'd64, 16'd0, 16'd0, 10'd0);
        wraps = 0;
        for (int k = 0; k <= 1024; k++) begin
            check($sformatf("ramp_x%0d", k), 32'(x), 32'(k % 1024));
            if (k >= 1 && wrap) wraps++;
            if (k < 1024) tick();
        end
        check("ramp_wraps", 32'(wraps), 32'd1);
        abort_run();

        // Up-sweep: in-block increment is block index + 1, done after 32 samples
        launch(2'd1, 16'd64, 16'd256, 16'd64, 10'd0);
        exp_x = 0;
        for (int n = 0; n < 32; n++) begin
            check($sformatf("sweep_x%0d", n), 32'(x), 32'(exp_x));
            exp_x = exp_x + (n / 8) + 1;
            tick();
        end
        check("sweep_done",  32'(done),    32'd1);
        check("sweep_busy",  32'(busy),    32'd0);
        check("sweep_valid", 32'(x_valid), 32'd0);
        tick();
        check("sweep_done_pulse", 32'(done), 32'd0);

        // Single-wrap: count valid samples until done, bounded
        launch(2'd2, 16'd1024, 16'd0, 16'd0, 10'd0);
        nvalid = 0;
        seen = 0;
        wrap_at_done = 0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                seen = 1;
                wrap_at_done = int'(wrap);
                break;
            end
            if (x_valid) nvalid++;
            tick();
        end
        check("single_done_seen", 32'(seen),         32'd1);
        check("single_nvalid",    32'(nvalid),       32'd64);
        check("single_wrap_done", 32'(wrap_at_done), 32'd1);
        tick();

        // Start during RUN is ignored; stop on the 10th sample holds x=9
        launch(2'd0, 16'd64, 16'd0, 16'd0, 10'd0);
        repeat (5) tick();
        check("stop_x5", 32'(x), 32'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_start_ignored", 32'(x), 32'd6);
        repeat (3) tick();
        check("stop_x9", 32'(x), 32'd9);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_valid", 32'(x_valid),   32'd0);
        check("stop_hold",  32'(x),         32'd9);
        check("stop_done",  32'(done),      32'd0);
        check("stop_ready", 32'(cfg_ready), 32'd1);
        check("stop_busy",  32'(busy),      32'd0);

        // Stop in IDLE is ignored; a captured cfg is kept until start
        stop = 1'b1;
        cfg_mode      = 2'd0;
        cfg_fcw       = 16'd64;
        cfg_fcw_end   = 16'd0;
        cfg_step      = 16'd0;
        cfg_phase_off = 10'd100;
        cfg_valid     = 1'b1;
        tick();
        stop = 1'b0;
        cfg_valid = 1'b0;
        cfg_fcw = 16'd999;
        cfg_phase_off = 10'd7;
        check("idle_stop_ready", 32'(cfg_ready), 32'd1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("held_cfg_x0", 32'(x), 32'd100);
        tick();
        check("held_cfg_x1", 32'(x), 32'd101);
        abort_run();

        // Asynchronous reset mid-sweep, then cfg+start in one cycle after release
        launch(2'd1, 16'd64, 16'd256, 16'd64, 10'd3);
        repeat (12) tick();
        rst_n = 1'b0;
        #1;
        check("mrst_x",     32'(x),       32'd0);
        check("mrst_valid", 32'(x_valid), 32'd0);
        check("mrst_wrap",  32'(wrap),    32'd0);
        check("mrst_busy",  32'(busy),    32'd0);
        check("mrst_done",  32'(done),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        launch(2'd0, 16'd128, 16'd0, 16'd0, 10'd5);
        check("post_rst_x0",   32'(x),    32'd5);
        check("post_rst_busy", 32'(busy), 32'd1);
        tick();
        check("post_rst_x1",   32'(x),       32'd7);
        check("post_rst_done", 32'(done),    32'd0);
        check("post_rst_valid", 32'(x_valid), 32'd1);
        abort_run();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nco_phase_gen.md
NCO_PHASE_GEN -- requirements
Module: nco_phase_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 16, accumulator width in bits.
REQ-002 SHALL have parameter PH_W, default 10, width of phase output x (matches sine/cosine ROM address).
REQ-003 SHALL have parameter SWEEP_DIV, default 8, samples between frequency-step updates in sweep mode.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cfg_valid, input, 1, configuration offered.
REQ-007 SHALL have port cfg_ready, output, 1, configuration accepted when high with cfg_valid.
REQ-008 SHALL have port cfg_mode, input, 2, 0=continuous, 1=up-sweep, 2=single-wrap, 3=reserved (treated as 0).
REQ-009 SHALL have ports cfg_fcw, input, ACC_W, start frequency control word; and cfg_fcw_end, input, ACC_W, sweep end word.
REQ-010 SHALL have ports cfg_step, input, ACC_W, sweep increment; and cfg_phase_off, input, PH_W, phase offset.
REQ-011 SHALL have ports start, input, 1, begin generation; and stop, input, 1, abort generation.
REQ-012 SHALL have port x, output, PH_W, registered phase sample for the sine/cosine ROM.
REQ-013 SHALL have ports x_valid, output, 1, x is a live sample; and wrap, output, 1, one-cycle accumulator-overflow pulse.
REQ-014 SHALL have ports busy, output, 1, high outside IDLE; and done, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, SWEEP; cfg_ready = 1 only in IDLE.
REQ-016 SHALL capture all cfg_* fields on cfg_valid&&cfg_ready; cfg held until next capture.
REQ-017 SHALL, on start in IDLE, clear acc to 0, load fcw_cur=cfg_fcw, enter SWEEP if mode 1, else RUN.
REQ-018 SHALL, when cfg_valid and start are high in the same IDLE cycle, use the newly captured cfg for that start.
REQ-019 SHALL present x = acc[ACC_W-1 -: PH_W] + phase_off mod 2^PH_W, x_valid=1, in every RUN/SWEEP cycle; first valid sample (cycle after start) is x=phase_off.
REQ-020 SHALL update acc <= acc + fcw_cur mod 2^ACC_W each valid cycle; wrap=1 in the cycle following a carry out.
REQ-021 SHALL, in SWEEP, add cfg_step to fcw_cur every SWEEP_DIV valid samples, saturating at cfg_fcw_end.
REQ-022 SHALL, in SWEEP, pulse done and return to IDLE on the step boundary where fcw_cur already equals cfg_fcw_end; cfg_fcw_end <= cfg_fcw ends at the first boundary.
REQ-023 SHALL treat cfg_step=0 in mode 1 as continuous (no done, runs until stop).
REQ-024 SHALL, in mode 2, pulse done and return to IDLE in the cycle wrap asserts.
REQ-025 SHALL, on stop in RUN/SWEEP, return to IDLE next cycle without done; stop has priority over done and start; stop in IDLE ignored.
REQ-026 SHALL hold x at its last value in IDLE with x_valid=0; start in RUN/SWEEP ignored.

Reset
REQ-027 SHALL on rst_n=0 force IDLE, acc=0, fcw_cur=0, x=0, x_valid=0, wrap=0, busy=0, done=0, cfg registers=0, asynchronously.
REQ-028 SHALL abandon any active run on mid-operation reset; first start after release uses freshly captured cfg.

Structure
REQ-029 SHALL place FSM state enum, cfg_mode encodings and default widths in shared package nco_pkg.
REQ-030 SHALL isolate accumulator+offset adder+wrap detect in one sub-module nco_phase_acc; FSM and sweep counter stay in top.

Verification
REQ-031 SHALL verify mode 0, fcw=64, off=0: x=0,1,2,...,1023,0 on consecutive cycles; wrap once per 1024 samples.
REQ-032 SHALL verify mode 0, fcw=64, off=256: first x=256; x=0 at sample 768.
REQ-033 SHALL verify mode 1, fcw=64, step=64, end=256, SWEEP_DIV=8: x increment 1,2,3,4 per 8-sample block; done after 32 samples, busy drops.
REQ-034 SHALL verify mode 2, fcw=1024: exactly 64 valid samples, done coincident with wrap.
REQ-035 SHALL verify stop at sample 10 in mode 0: x_valid low next cycle, x holds 9, no done, cfg_ready=1.
REQ-036 SHALL verify rst_n asserted mid-sweep: all outputs zero immediately; cfg_valid+start same cycle after release uses new cfg.
